// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared types and constants for the FAST scan sequencer
package fast_pkg;

    localparam int FAST_RADIUS     = 3;
    localparam int DEFAULT_COORD_W = 10;

    typedef logic [DEFAULT_COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/fast_scan_ctrl_if.sv
// rtl/fast_scan_ctrl_if.sv - coordinate stream from the scan sequencer to the window fetch stage
interface fast_scan_ctrl_if
    import fast_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W
);

    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;

    modport master (
        output out_valid,
        output out_x,
        output out_y,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_x,
        input  out_y,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/scan_axis_counter.sv
// rtl/scan_axis_counter.sv - one raster axis: loadable up-counter that wraps back to its load value
module scan_axis_counter
    import fast_pkg::*;
#(
    parameter int W = DEFAULT_COORD_W
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         at_limit
);

    assign at_limit = (value == limit);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (enable) begin
            value <= at_limit ? load_val : value + W'(1);
        end
    end

endmodule

// File: rtl/fast_scan_ctrl.sv
// rtl/fast_scan_ctrl.sv - raster-scan sequencer emitting every pixel whose radius-BORDER circle fits in the image
module fast_scan_ctrl
    import fast_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W,
    parameter int BORDER  = FAST_RADIUS
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] img_width,
    input  logic [COORD_W-1:0] img_height,
    fast_scan_ctrl_if.master   coord,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [COORD_W-1:0] BORDER_C  = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] EDGE_SPAN = COORD_W'(BORDER + 1);
    localparam logic [COORD_W:0]   MIN_DIM   = (COORD_W+1)'(2 * BORDER);

    scan_state_t        state;
    logic [COORD_W-1:0] x_limit;
    logic [COORD_W-1:0] y_limit;
    logic [COORD_W-1:0] x_val;
    logic [COORD_W-1:0] y_val;
    logic               x_at_limit;
    logic               y_at_limit;
    logic               cfg_ok;
    logic               accept_start;
    logic               xfer;
    logic               frame_end;

    // Extra top bit so 2*BORDER never aliases for dimensions near 2**COORD_W.
    assign cfg_ok = ({1'b0, img_width} > MIN_DIM) && ({1'b0, img_height} > MIN_DIM);

    assign accept_start = (state == IDLE) && start && !abort;
    assign xfer         = (state == SCAN) && coord.out_ready && !abort;
    assign frame_end    = xfer && x_at_limit && y_at_limit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            x_limit <= '0;
            y_limit <= '0;
            cfg_err <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_limit <= img_width - EDGE_SPAN;
                        y_limit <= img_height - EDGE_SPAN;
                        cfg_err <= !cfg_ok;
                        state   <= cfg_ok ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    if (frame_end) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    scan_axis_counter #(.W(COORD_W)) u_x_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (accept_start && cfg_ok),
        .load_val (BORDER_C),
        .enable   (xfer),
        .limit    (x_limit),
        .value    (x_val),
        .at_limit (x_at_limit)
    );

    // Row holds on the final coordinate so the frame ends on the last row, not wrapped.
    scan_axis_counter #(.W(COORD_W)) u_y_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (accept_start && cfg_ok),
        .load_val (BORDER_C),
        .enable   (xfer && x_at_limit && !y_at_limit),
        .limit    (y_limit),
        .value    (y_val),
        .at_limit (y_at_limit)
    );

    assign coord.out_valid = (state == SCAN);
    assign coord.out_x     = x_val;
    assign coord.out_y     = y_val;
    assign coord.out_last  = (state == SCAN) && x_at_limit && y_at_limit;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fast_scan_ctrl.sv
// tb/tb_fast_scan_ctrl.sv - directed self-checking bench for fast_scan_ctrl
module tb_fast_scan_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       abort;
    logic [9:0] img_width;
    logic [9:0] img_height;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    fast_scan_ctrl_if #(.COORD_W(10)) coord_bus ();

    fast_scan_ctrl #(.COORD_W(10), .BORDER(3)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .img_width  (img_width),
        .img_height (img_height),
        .coord      (coord_bus),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // {valid, last, busy, done, cfg_err, x, y}
    function automatic logic [24:0] obs();
        return {coord_bus.out_valid, coord_bus.out_last, busy, done, cfg_err,
                coord_bus.out_x, coord_bus.out_y};
    endfunction

    function automatic logic [24:0] vec(input logic v, input logic l, input logic b,
                                        input logic d, input logic e,
                                        input int x, input int y);
        return {v, l, b, d, e, 10'(x), 10'(y)};
    endfunction

    function automatic string fmt(input logic [24:0] s);
        return $sformatf("valid=%b last=%b busy=%b done=%b cfg_err=%b x=%0d y=%0d",
                         s[24], s[23], s[22], s[21], s[20], s[19:10], s[9:0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int w, input int h);
        img_width  = 10'(w);
        img_height = 10'(h);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        img_width  = '0;
        img_height = '0;
        coord_bus.out_ready = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== 25'd0) begin
            errors++;
            $display("FAIL reset_state got %s required %s", fmt(obs()), fmt(25'd0));
        end
        n_rst = 1'b1;
        step();
        checks++;
        if (obs() !== 25'd0) begin
            errors++;
            $display("FAIL reset_release got %s required %s", fmt(obs()), fmt(25'd0));
        end
    endtask

    task automatic test_basic();
        coord_bus.out_ready = 1'b1;
        launch(8, 8);
        for (int i = 0; i < 4; i++) begin
            logic [24:0] e;
            e = vec(1'b1, i == 3, 1'b1, 1'b0, 1'b0, 3 + i % 2, 3 + i / 2);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL basic_coord%0d got %s required %s", i, fmt(obs()), fmt(e));
            end
            step();
        end
        checks++;
        if (obs() >> 20 !== 25'b00110) begin
            errors++;
            $display("FAIL basic_done got %s required valid=0 busy=1 done=1", fmt(obs()));
        end
        step();
        checks++;
        if (obs() >> 20 !== 25'b00000) begin
            errors++;
            $display("FAIL basic_idle got %s required valid=0 busy=0 done=0", fmt(obs()));
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        logic [3:0] pat = 4'b1001;
        launch(9, 7);
        while (!done && cyc < 40) begin
            if (coord_bus.out_valid) begin
                logic [24:0] e;
                e = vec(1'b1, idx == 2, 1'b1, 1'b0, 1'b0, 3 + idx, 3);
                checks++;
                if (idx > 2 || obs() !== e) begin
                    errors++;
                    $display("FAIL bp_coord%0d got %s required %s", idx, fmt(obs()), fmt(e));
                end
            end
            coord_bus.out_ready = pat[3 - (cyc % 4)];
            if (coord_bus.out_valid && coord_bus.out_ready) idx++;
            step();
            cyc++;
        end
        checks++;
        if (!done || idx != 3) begin
            errors++;
            $display("FAIL bp_count got transfers=%0d done=%b required transfers=3 done=1", idx, done);
        end
        coord_bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_bad_cfg();
        launch(6, 20);
        checks++;
        if (obs() >> 20 !== 25'b00111) begin
            errors++;
            $display("FAIL badcfg_done got %s required valid=0 busy=1 done=1 cfg_err=1", fmt(obs()));
        end
        step();
        checks++;
        if (obs() >> 20 !== 25'b00001) begin
            errors++;
            $display("FAIL badcfg_idle got %s required valid=0 busy=0 done=0 cfg_err=1", fmt(obs()));
        end
        step();
        checks++;
        if (obs() >> 20 !== 25'b00001) begin
            errors++;
            $display("FAIL badcfg_hold got %s required cfg_err=1 only", fmt(obs()));
        end
    endtask

    task automatic test_minimal();
        coord_bus.out_ready = 1'b1;
        launch(7, 10);
        for (int i = 0; i < 4; i++) begin
            logic [24:0] e;
            e = vec(1'b1, i == 3, 1'b1, 1'b0, 1'b0, 3, 3 + i);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL minimal_coord%0d got %s required %s", i, fmt(obs()), fmt(e));
            end
            step();
        end
        checks++;
        if (obs() >> 20 !== 25'b00110) begin
            errors++;
            $display("FAIL minimal_done got %s required valid=0 busy=1 done=1", fmt(obs()));
        end
        step();
    endtask

    task automatic test_abort();
        coord_bus.out_ready = 1'b1;
        launch(16, 16);
        for (int i = 0; i < 10; i++) begin
            logic [24:0] e;
            e = vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3 + i, 3);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL abort_coord%0d got %s required %s", i, fmt(obs()), fmt(e));
            end
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (obs() >> 20 !== 25'b00000) begin
            errors++;
            $display("FAIL abort_idle got %s required valid=0 last=0 busy=0 done=0", fmt(obs()));
        end
        step();
        checks++;
        if (obs() >> 20 !== 25'b00000) begin
            errors++;
            $display("FAIL abort_nodone got %s required valid=0 busy=0 done=0", fmt(obs()));
        end
        img_width  = 10'd8;
        img_height = 10'd8;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (obs() >> 20 !== 25'b00000) begin
            errors++;
            $display("FAIL abort_beats_start got %s required valid=0 busy=0", fmt(obs()));
        end
        launch(8, 8);
        checks++;
        if (obs() !== vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3)) begin
            errors++;
            $display("FAIL abort_restart got %s required valid=1 x=3 y=3", fmt(obs()));
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_start_busy_reset();
        coord_bus.out_ready = 1'b1;
        launch(8, 8);
        for (int i = 0; i < 4; i++) begin
            logic [24:0] e;
            e = vec(1'b1, i == 3, 1'b1, 1'b0, 1'b0, 3 + i % 2, 3 + i / 2);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL busy_coord%0d got %s required %s", i, fmt(obs()), fmt(e));
            end
            if (i == 1) begin
                img_width  = 10'd16;
                img_height = 10'd16;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        checks++;
        if (obs() >> 20 !== 25'b00110) begin
            errors++;
            $display("FAIL busy_done got %s required valid=0 busy=1 done=1", fmt(obs()));
        end
        step();
        launch(8, 8);
        step();
        checks++;
        if (obs() !== vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 3)) begin
            errors++;
            $display("FAIL rst_pre got %s required valid=1 x=4 y=3", fmt(obs()));
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if (obs() !== 25'd0) begin
            errors++;
            $display("FAIL rst_async got %s required %s", fmt(obs()), fmt(25'd0));
        end
        step();
        n_rst = 1'b1;
        step();
        checks++;
        if (obs() !== 25'd0) begin
            errors++;
            $display("FAIL rst_after got %s required %s", fmt(obs()), fmt(25'd0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_cfg();
        test_minimal();
        test_abort();
        test_start_busy_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
